// File: rtl/cpu_pkg.sv
// Shared constants and types for the LEGv8 pipeline.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned ADDR_W = 64;

    // ADDI X31,X31,#0 is the architectural no-op used for pipeline bubbles.
    localparam logic [INST_W-1:0] NOP_INST         = 32'h910003FF;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic [INST_W-1:0] inst;
        logic              valid;
    } if_id_t;

endpackage

// File: rtl/add_64.sv
// 64-bit adder, wraps modulo 2^64 with no carry out.
module add_64 (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: synchronous reset, hold on !en_i, bubble insert on flush_i.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INST_W-1:0] NopInst = cpu_pkg::NOP_INST
) (
    input  logic   clk_i,
    input  logic   reset_i,
    input  logic   en_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);

    if_id_t q_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q.pc    <= '0;
            q_q.pc4   <= '0;
            q_q.inst  <= NopInst;
            q_q.valid <= 1'b0;
        end else if (en_i) begin
            q_q.pc  <= d_i.pc;
            q_q.pc4 <= d_i.pc4;
            // The fetched word is never loaded on flush so no X reaches decode.
            if (flush_i) begin
                q_q.inst  <= NopInst;
                q_q.valid <= 1'b0;
            end else begin
                q_q.inst  <= d_i.inst;
                q_q.valid <= d_i.valid;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/mux2_1x64.sv
// Two-input 64-bit multiplexer; sel_i = 1 picks in1_i.
module mux2_1x64 (
    input  logic [63:0] in0_i,
    input  logic [63:0] in1_i,
    input  logic        sel_i,
    output logic [63:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/if_stage.sv
// LEGv8 instruction-fetch stage: PC register, next-PC selection and IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Inst_IF,
    output logic [63:0] Addr_IF,
    input  logic [63:0] Add_offset,
    input  logic        orR0,
    input  logic        Reg2PC_ID,
    input  logic [63:0] Rd2_Reg_out_ID,
    input  logic        stall,
    output logic [63:0] PC_out_ID,
    output logic [63:0] Add_4_ID,
    output logic [31:0] Inst_ID,
    output logic        Valid_ID
);

    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] pc4;
    logic [63:0] target_raw;
    logic [63:0] target;
    logic        redirect;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    add_64 u_pc4_add (
        .a_i   (pc_q),
        .b_i   (64'd4),
        .sum_o (pc4)
    );

    // Register target (BR) takes precedence over the decode-computed offset target.
    mux2_1x64 u_target_mux (
        .in0_i (Add_offset),
        .in1_i (Rd2_Reg_out_ID),
        .sel_i (Reg2PC_ID),
        .out_o (target_raw)
    );

    assign redirect = orR0 | Reg2PC_ID;
    assign target   = target_raw & ~64'd3;

    // Stall wins over redirect: decode operands are not yet valid while stalled.
    always_comb begin
        pc_d = pc4;
        if (stall) begin
            pc_d = pc_q;
        end else if (redirect) begin
            pc_d = target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_comb begin
        if_id_d.pc    = pc_q;
        if_id_d.pc4   = pc4;
        if_id_d.inst  = Inst_IF;
        if_id_d.valid = 1'b1;
    end

    if_id_reg #(
        .NopInst (NOP_INST)
    ) u_if_id_reg (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (~stall),
        .flush_i (redirect),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign Addr_IF   = pc_q;
    assign PC_out_ID = if_id_q.pc;
    assign Add_4_ID  = if_id_q.pc4;
    assign Inst_ID   = if_id_q.inst;
    assign Valid_ID  = if_id_q.valid;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a cycle-level reference model and literal spot checks.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h910003FF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Inst_IF;
    logic [63:0] Addr_IF;
    logic [63:0] Add_offset;
    logic        orR0;
    logic        Reg2PC_ID;
    logic [63:0] Rd2_Reg_out_ID;
    logic        stall;
    logic [63:0] PC_out_ID;
    logic [63:0] Add_4_ID;
    logic [31:0] Inst_ID;
    logic        Valid_ID;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state
    logic [63:0] m_pc, m_id_pc, m_id_pc4;
    logic [31:0] m_inst;
    logic        m_valid;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return 32'hAAAA0000 | a[31:0];
    endfunction

    assign Inst_IF = mem(Addr_IF);

    if_stage dut (
        .clk            (clk),
        .reset          (reset),
        .Inst_IF        (Inst_IF),
        .Addr_IF        (Addr_IF),
        .Add_offset     (Add_offset),
        .orR0           (orR0),
        .Reg2PC_ID      (Reg2PC_ID),
        .Rd2_Reg_out_ID (Rd2_Reg_out_ID),
        .stall          (stall),
        .PC_out_ID      (PC_out_ID),
        .Add_4_ID       (Add_4_ID),
        .Inst_ID        (Inst_ID),
        .Valid_ID       (Valid_ID)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: what the fetch stage must hold after each clock edge.
    always @(posedge clk) begin
        logic [63:0] tgt;
        if (reset) begin
            m_pc = 64'h0; m_id_pc = 64'h0; m_id_pc4 = 64'h0; m_inst = NOP; m_valid = 1'b0;
        end else if (!stall) begin
            tgt = Reg2PC_ID ? Rd2_Reg_out_ID : Add_offset;
            tgt = {tgt[63:2], 2'b00};
            m_id_pc  = m_pc;
            m_id_pc4 = m_pc + 64'd4;
            if (orR0 || Reg2PC_ID) begin
                m_inst = NOP; m_valid = 1'b0; m_pc = tgt;
            end else begin
                m_inst = mem(m_pc); m_valid = 1'b1; m_pc = m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_addr",  Addr_IF,   m_pc);
            check("m_pc_id", PC_out_ID, m_id_pc);
            check("m_pc4",   Add_4_ID,  m_id_pc4);
            check("m_inst",  {32'h0, Inst_ID}, {32'h0, m_inst});
            check("m_valid", {63'h0, Valid_ID}, {63'h0, m_valid});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        orR0 = 0; Reg2PC_ID = 0; stall = 0; Add_offset = 0; Rd2_Reg_out_ID = 0;
    endtask

    initial begin
        reset = 1; clr();
        cyc(); cyc();
        chk_en = 1'b1;
        reset = 0;
        check("post_rst_addr",  Addr_IF, 64'h0);
        check("post_rst_valid", {63'h0, Valid_ID}, 64'h0);
        check("post_rst_inst",  {32'h0, Inst_ID}, {32'h0, NOP});
        cyc();
        check("first_inst",  {32'h0, Inst_ID}, 64'hAAAA0000);
        check("first_pc",    PC_out_ID, 64'h0);
        check("first_pc4",   Add_4_ID, 64'h4);
        check("first_valid", {63'h0, Valid_ID}, 64'h1);
        check("seq_addr4",   Addr_IF, 64'h4);
        cyc(); check("seq_addr8", Addr_IF, 64'h8);
        cyc(); check("seq_addr12", Addr_IF, 64'hC);
        check("seq_lag", {32'h0, Inst_ID}, 64'hAAAA0008);
        cyc(); check("seq_addr16", Addr_IF, 64'h10);

        // Taken branch at PC 16
        orR0 = 1; Add_offset = 64'h100;
        cyc(); clr();
        check("br_addr",  Addr_IF, 64'h100);
        check("br_inst",  {32'h0, Inst_ID}, {32'h0, NOP});
        check("br_valid", {63'h0, Valid_ID}, 64'h0);
        cyc();
        check("br_tgt_inst",  {32'h0, Inst_ID}, 64'hAAAA0100);
        check("br_tgt_valid", {63'h0, Valid_ID}, 64'h1);

        // BR wins over offset target, low bits cleared
        Reg2PC_ID = 1; orR0 = 1; Rd2_Reg_out_ID = 64'h203; Add_offset = 64'h40;
        cyc(); clr();
        check("breg_addr", Addr_IF, 64'h200);
        cyc();

        // Stall at PC 8 with a real instruction in IF/ID
        orR0 = 1; Add_offset = 64'h0;
        cyc(); clr(); cyc(); cyc();
        check("pre_stall_addr", Addr_IF, 64'h8);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_addr", Addr_IF, 64'h8);
            check("stall_inst", {32'h0, Inst_ID}, 64'hAAAA0004);
            check("stall_pc",   PC_out_ID, 64'h4);
        end
        stall = 0;
        cyc();
        check("unstall_addr", Addr_IF, 64'hC);
        check("unstall_inst", {32'h0, Inst_ID}, 64'hAAAA0008);

        // Stall overrides redirect until it drops
        stall = 1; orR0 = 1; Add_offset = 64'h80;
        cyc();
        check("sr_hold", Addr_IF, 64'hC);
        stall = 0;
        cyc(); clr();
        check("sr_addr",  Addr_IF, 64'h80);
        check("sr_valid", {63'h0, Valid_ID}, 64'h0);
        check("sr_pc",    PC_out_ID, 64'hC);

        // PC wrap
        orR0 = 1; Add_offset = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc(); clr();
        check("wrap_top", Addr_IF, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        check("wrap_addr", Addr_IF, 64'h0);
        check("wrap_pc4",  Add_4_ID, 64'h0);
        check("wrap_inst", {32'h0, Inst_ID}, 64'hFFFFFFFC);
        cyc(); cyc();

        // Reset during redirect, then during stall
        reset = 1; orR0 = 1; Add_offset = 64'h40;
        cyc();
        check("rr_addr",  Addr_IF, 64'h0);
        check("rr_valid", {63'h0, Valid_ID}, 64'h0);
        reset = 0; clr();
        cyc(); cyc(); cyc();
        reset = 1; stall = 1;
        cyc();
        check("rs_addr", Addr_IF, 64'h0);
        check("rs_inst", {32'h0, Inst_ID}, {32'h0, NOP});
        reset = 0; clr();
        cyc(); cyc();
        check("rs_after", Addr_IF, 64'h8);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined LEGv8 CPU; sits directly upstream of the decode stage.
- Holds the PC and selects the next PC from PC+4, the decode-stage branch target, or the decode-stage register target (BR).
- Drives the external instruction memory address and captures the fetched word into the IF/ID pipeline register.
- Supports stall from the hazard detection unit and flush on taken branches.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INST, 32'h910003FF (ADDI X31,X31,#0), instruction injected into IF/ID on flush/reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Inst_IF  input  32  instruction memory read data; combinational from Addr_IF, same cycle.
- Addr_IF  output  64  instruction memory address (current PC).
- Add_offset  input  64  branch/B/BL target computed in decode.
- orR0  input  1  branch-taken from decode (B, BL, taken CBZ/B.LT).
- Reg2PC_ID  input  1  decode holds BR; target is Rd2_Reg_out_ID.
- Rd2_Reg_out_ID  input  64  register-file read data 2 (BR target).
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- PC_out_ID  output  64  IF/ID: PC of the instruction in decode.
- Add_4_ID  output  64  IF/ID: that PC + 4 (BL link value).
- Inst_ID  output  32  IF/ID: instruction in decode.
- Valid_ID  output  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - PC <= RESET_PC.
  - PC_out_ID <= 0, Add_4_ID <= 0, Inst_ID <= NOP_INST, Valid_ID <= 0.
- Combinational outputs:
  - Addr_IF = PC.
  - PC4 = PC + 64'd4, modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- Redirect:
  - redirect = orR0 | Reg2PC_ID.
  - target = Rd2_Reg_out_ID if Reg2PC_ID, else Add_offset (Reg2PC_ID wins if both are asserted).
  - target[1:0] is forced to 2'b00 before loading into the PC.
- Per-cycle update priority when not in reset:
  1. stall = 1: PC and all IF/ID outputs hold. Stall overrides redirect, because decode's branch operands are not yet valid; the redirect is re-evaluated on the first cycle after stall drops.
  2. redirect = 1: PC <= target. IF/ID is flushed: Inst_ID <= NOP_INST, Valid_ID <= 0, PC_out_ID <= PC, Add_4_ID <= PC4. The wrong-path word fetched this cycle is discarded.
  3. Otherwise: PC <= PC4, PC_out_ID <= PC, Add_4_ID <= PC4, Inst_ID <= Inst_IF, Valid_ID <= 1.
- Latency and throughput:
  - An instruction at PC X is presented on Inst_ID exactly one cycle after Addr_IF = X, absent stall or flush.
  - Branch penalty: exactly 1 bubble per taken redirect.
- First cycle after reset deasserts: Addr_IF = RESET_PC, Valid_ID = 0. First valid decode occurs one cycle later.
- A reset asserted mid-stall or mid-redirect overrides both.
- No other state. No X may propagate from Inst_IF into Inst_ID while flushed or in reset.

Decomposition:
- Shared package cpu_pkg:
  - constants NOP_INST, RESET_PC default, INST_W = 32, ADDR_W = 64.
  - typedef if_id_t struct {pc, pc4, inst, valid}.
- One sub-module, if_id_reg: the IF/ID pipeline register with synchronous reset, enable (~stall) and flush (load NOP/valid = 0).
- PC register, next-PC mux and PC+4 adder stay in if_stage. Reuse the existing add_64 and mux2_1x64 blocks.

Test Plan:
- Reset held 2 cycles, then released, with memory word = 32'hAAAA0000 | addr:
  - First post-reset cycle: Addr_IF = 0, Valid_ID = 0.
  - Next cycle: Inst_ID = 32'hAAAA0000, PC_out_ID = 0, Add_4_ID = 4, Valid_ID = 1.
  - Addresses then advance 4, 8, 12.
- Sequential run: 5 cycles, no control inputs -> Addr_IF = 0, 4, 8, 12, 16; Inst_ID lags Addr_IF by one cycle.
- Taken branch: at PC = 16, orR0 = 1, Add_offset = 64'h100 ->
  - next cycle: Addr_IF = 64'h100, Inst_ID = NOP_INST, Valid_ID = 0;
  - following cycle: Inst_ID = word@0x100, Valid_ID = 1.
- BR: Reg2PC_ID = 1, orR0 = 1, Rd2_Reg_out_ID = 64'h203, Add_offset = 64'h40 -> Addr_IF = 64'h200 (register target wins, low bits cleared).
- Stall: stall = 1 for 3 cycles at PC = 8 -> Addr_IF stays 8 and IF/ID holds. When stall drops, Addr_IF = 12.
- Stall + redirect together: stall = 1, orR0 = 1, Add_offset = 64'h80 ->
  - PC holds while stalled;
  - next cycle with stall = 0 and orR0 still 1: Addr_IF = 64'h80 and a flush occurs.
- PC wrap: force PC = 64'hFFFF_FFFF_FFFF_FFFC -> next Addr_IF = 0, Add_4_ID = 0.
- Reset mid-redirect: reset = 1 with orR0 = 1 -> Addr_IF = RESET_PC, Valid_ID = 0.
